axicb_slv_wr_order: RTL and testbench

- Write-data ordering stage for one slave port of the crossbar, alongside the per-slave master arbitration switch.
- Records, in order, which master won each accepted write-address (AW) handshake.
- Routes the write-data (W) channel from that master only, one full burst (through WLAST) per recorded grant. This prevents W beats from different masters interleaving or arriving out of AW order.
- Also back-pressures AW acceptance when the order queue is full.

---
 rtl/axicb_slv_wr_order.sv | 113 +++++++++++
 tb/tb_axicb_slv_wr_order.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/axicb_slv_wr_order.sv
// Write-data ordering stage for one crossbar slave port: queues AW grant order and routes W bursts in that order.
// Optional same-cycle AW->W bypass on an empty queue: define AXICB_WR_ORDER_BYPASS_EN.
module axicb_slv_wr_order #(
  parameter int MST_NB      = 4,
  parameter int WCH_W       = 8,
  parameter int OSTDREQ_NUM = 4,
  parameter int MST_IDX_W   = 2
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    srst,
  input  logic [MST_NB-1:0]       aw_grant,
  input  logic                    aw_en,
  output logic                    aw_allow,
  input  logic [MST_NB-1:0]       i_wvalid,
  output logic [MST_NB-1:0]       i_wready,
  input  logic [MST_NB-1:0]       i_wlast,
  input  logic [MST_NB*WCH_W-1:0] i_wch,
  output logic                    o_wvalid,
  input  logic                    o_wready,
  output logic                    o_wlast,
  output logic [WCH_W-1:0]        o_wch,
  output logic [$clog2(OSTDREQ_NUM):0] pending
);

  localparam int PTR_W = $clog2(OSTDREQ_NUM);
  localparam int CNT_W = PTR_W + 1;

  logic [MST_IDX_W-1:0] order_mem [OSTDREQ_NUM];
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W-1:0]     rd_ptr_reg;
  logic [CNT_W-1:0]     count_reg;
  logic [CNT_W-1:0]     count_next;

  logic [MST_IDX_W-1:0] grant_idx;
  logic                 grant_any;
  logic                 queue_full;
  logic                 push;
  logic                 pop;
  logic                 head_valid;
  logic [MST_IDX_W-1:0] head_idx;
  logic [MST_NB-1:0]    head_oh;

  // Lowest set bit wins when the grant is not one-hot.
  always_comb begin
    grant_idx = '0;
    for (int k = MST_NB - 1; k >= 0; k--) begin
      if (aw_grant[k]) grant_idx = MST_IDX_W'(k);
    end
  end

  assign grant_any  = |aw_grant;
  assign queue_full = (count_reg == CNT_W'(OSTDREQ_NUM));
  assign aw_allow   = !queue_full;
  assign push       = aw_en && grant_any && !queue_full;
  assign pop        = o_wvalid && o_wready && o_wlast;
  assign count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
  assign pending    = count_reg;

  always_comb begin
    head_valid = (count_reg != '0);
    head_idx   = order_mem[rd_ptr_reg];
`ifdef AXICB_WR_ORDER_BYPASS_EN
    // Empty queue: steer W straight from the grant being accepted this cycle.
    if (count_reg == '0 && aw_en && grant_any) begin
      head_valid = 1'b1;
      head_idx   = grant_idx;
    end
`endif
  end

  generate
    for (genvar gi = 0; gi < MST_NB; gi++) begin : g_sel
      assign head_oh[gi]  = head_valid && (head_idx == MST_IDX_W'(gi));
      assign i_wready[gi] = head_oh[gi] & o_wready;
    end
  endgenerate

  always_comb begin
    o_wvalid = 1'b0;
    o_wlast  = 1'b0;
    o_wch    = '0;
    for (int k = 0; k < MST_NB; k++) begin
      if (head_oh[k]) begin
        o_wvalid = i_wvalid[k];
        o_wlast  = i_wlast[k];
        o_wch    = i_wch[k*WCH_W +: WCH_W];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  // Entries need no reset: only slots covered by count are ever read as head.
  always_ff @(posedge aclk) begin
    if (push) order_mem[wr_ptr_reg] <= grant_idx;
  end

endmodule

// File: tb/tb_axicb_slv_wr_order.sv
// Bench for axicb_slv_wr_order: directed order/full/simultaneous/empty/reset steps plus random traffic against a queue model.
module tb_axicb_slv_wr_order;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        srst;
  logic [3:0]  aw_grant;
  logic        aw_en;
  logic        aw_allow;
  logic [3:0]  i_wvalid;
  logic [3:0]  i_wready;
  logic [3:0]  i_wlast;
  logic [31:0] i_wch;
  logic        o_wvalid;
  logic        o_wready;
  logic        o_wlast;
  logic [7:0]  o_wch;
  logic [2:0]  pending;

  int vectors = 0;
  int miscompares = 0;
  int q[$];

  axicb_slv_wr_order #(
    .MST_NB(4), .WCH_W(8), .OSTDREQ_NUM(4), .MST_IDX_W(2)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .aw_grant(aw_grant), .aw_en(aw_en), .aw_allow(aw_allow),
    .i_wvalid(i_wvalid), .i_wready(i_wready), .i_wlast(i_wlast), .i_wch(i_wch),
    .o_wvalid(o_wvalid), .o_wready(o_wready), .o_wlast(o_wlast), .o_wch(o_wch),
    .pending(pending)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [3:0] g);
    for (int k = 0; k < 4; k++) if (g[k]) return k;
    return 0;
  endfunction

  // One clock: check all outputs against the queue model mid-cycle, then advance the model at the edge.
  task automatic cycle();
    int          h;
    logic        hv, ev, el, do_push, do_pop, do_clr;
    logic [7:0]  ec;
    logic [3:0]  er;
    @(negedge aclk);
    hv = 1'b0;
    h  = 0;
    if (q.size() > 0) begin
      hv = 1'b1;
      h  = q[0];
    end
`ifdef AXICB_WR_ORDER_BYPASS_EN
    else if (aw_en && aw_grant != 4'b0) begin
      hv = 1'b1;
      h  = lowest(aw_grant);
    end
`endif
    ev = hv && i_wvalid[h];
    el = hv && i_wlast[h];
    ec = hv ? i_wch[h*8 +: 8] : 8'h0;
    er = (hv && o_wready) ? 4'(1 << h) : 4'b0;
    check("o_wvalid", 32'(o_wvalid), 32'(ev));
    check("o_wlast",  32'(o_wlast),  32'(el));
    check("o_wch",    32'(o_wch),    32'(ec));
    check("i_wready", 32'(i_wready), 32'(er));
    check("pending",  32'(pending),  32'(q.size()));
    check("aw_allow", 32'(aw_allow), 32'(q.size() != 4));
    do_push = aw_en && (aw_grant != 4'b0) && (q.size() < 4);
    do_pop  = ev && o_wready && el;
    do_clr  = srst;
    @(posedge aclk);
    if (do_clr) q.delete();
    else begin
      if (do_push) q.push_back(lowest(aw_grant));
      if (do_pop)  void'(q.pop_front());
    end
    #1;
  endtask

  task automatic drive(input logic en, input logic [3:0] g, input logic [3:0] wv,
                       input logic [3:0] wl, input logic wr);
    aw_en    = en;
    aw_grant = g;
    i_wvalid = wv;
    i_wlast  = wl;
    o_wready = wr;
    i_wch    = $urandom;
    cycle();
  endtask

  initial begin
    aresetn = 1'b0; srst = 1'b0; aw_en = 1'b0; aw_grant = '0;
    i_wvalid = '0; i_wlast = '0; i_wch = '0; o_wready = 1'b0;
    #1;
    check("rst_pending",  32'(pending),  32'd0);
    check("rst_aw_allow", 32'(aw_allow), 32'd1);
    check("rst_o_wvalid", 32'(o_wvalid), 32'd0);
    check("rst_i_wready", 32'(i_wready), 32'd0);
    check("rst_o_wch",    32'(o_wch),    32'd0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    drive(0, 4'b0000, 4'b0000, 4'b0000, 1);

    // Order: m2 then m0, 2-beat bursts each
    drive(1, 4'b0100, 4'b0000, 4'b0000, 1);
    drive(1, 4'b0001, 4'b0101, 4'b0000, 1);
    drive(0, 4'b0000, 4'b0101, 4'b0100, 1);
    drive(0, 4'b0000, 4'b0101, 4'b0000, 1);
    drive(0, 4'b0000, 4'b0101, 4'b0001, 1);
    drive(0, 4'b0000, 4'b0000, 4'b0000, 1);

    // Full: four AWs from m1, a dropped fifth, then drain with single-beat bursts
    for (int i = 0; i < 4; i++) drive(1, 4'b0010, 4'b0000, 4'b0000, 1);
    check("full_aw_allow", 32'(aw_allow), 32'd0);
    drive(1, 4'b0010, 4'b0000, 4'b0000, 1);
    check("full_pending_after_drop", 32'(pending), 32'd4);
    for (int i = 0; i < 4; i++) drive(0, 4'b0000, 4'b0010, 4'b0010, 1);
    drive(0, 4'b0000, 4'b0000, 4'b0000, 1);

    // Simultaneous push of m1 with m3's WLAST handshake
    drive(1, 4'b1000, 4'b0000, 4'b0000, 1);
    drive(1, 4'b0010, 4'b1010, 4'b1010, 1);
    check("simul_pending", 32'(pending), 32'd1);
    drive(0, 4'b0000, 4'b1010, 4'b1010, 1);

    // Empty: all masters valid, then AW for m0 with a single-beat burst
    drive(0, 4'b0000, 4'b1111, 4'b1111, 1);
    drive(1, 4'b0001, 4'b1111, 4'b1111, 1);
    drive(0, 4'b0000, 4'b1111, 4'b1111, 1);
    drive(0, 4'b0000, 4'b0000, 4'b0000, 1);

    // Random traffic including multi-hot and zero grants
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) < 4), 4'($urandom), 4'($urandom), 4'($urandom),
            ($urandom_range(0, 9) < 7));
    end
    for (int i = 0; i < 12; i++) drive(0, 4'b0000, 4'b1111, 4'b1111, 1);

    // Async reset mid-burst with three grants queued
    drive(1, 4'b0010, 4'b0000, 4'b0000, 1);
    drive(1, 4'b0100, 4'b0010, 4'b0000, 1);
    drive(1, 4'b1000, 4'b0010, 4'b0000, 1);
    aw_en = 1'b0;
    i_wvalid = 4'b1111;
    #2;
    check("pre_rst_pending", 32'(pending), 32'd3);
    aresetn = 1'b0;
    #1;
    q.delete();
    check("arst_pending",  32'(pending),  32'd0);
    check("arst_o_wvalid", 32'(o_wvalid), 32'd0);
    check("arst_aw_allow", 32'(aw_allow), 32'd1);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    drive(1, 4'b0100, 4'b1111, 4'b0000, 1);
    drive(0, 4'b0000, 4'b1111, 4'b0000, 1);
    drive(0, 4'b0000, 4'b1111, 4'b1111, 1);
    drive(0, 4'b0000, 4'b0000, 4'b0000, 1);

    // Synchronous clear for one edge mid-burst
    drive(1, 4'b0010, 4'b0000, 4'b0000, 1);
    drive(1, 4'b0100, 4'b0010, 4'b0000, 1);
    drive(1, 4'b1000, 4'b0010, 4'b0000, 1);
    srst = 1'b1;
    drive(0, 4'b0000, 4'b1111, 4'b0000, 1);
    srst = 1'b0;
    check("srst_pending",  32'(pending),  32'd0);
    check("srst_aw_allow", 32'(aw_allow), 32'd1);
    drive(1, 4'b0100, 4'b1111, 4'b0000, 1);
    drive(0, 4'b0000, 4'b1111, 4'b1111, 1);
    drive(0, 4'b0000, 4'b0000, 4'b0000, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
